seq_function_unit: RTL and testbench
====================================

SEQ_FUNCTION_UNIT -- requirements
Module: seq_function_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the operand/result width; legal values are powers of two, 8..64.
REQ-002 SHALL derive localparam SHW = log2(WIDTH), the shift-amount width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1: an operation is offered.
REQ-006 SHALL have port in_ready, output, 1: the unit accepts the offered operation this cycle.
REQ-007 SHALL have port A, input, WIDTH: the first operand.
REQ-008 SHALL have port B, input, WIDTH: the second operand.
REQ-009 SHALL have port FunctionSelect, input, 4: the opcode.
REQ-010 SHALL have port out_valid, output, 1: Result and the flags are valid.
REQ-011 SHALL have port out_ready, input, 1: the consumer takes the result.
REQ-012 SHALL have port Result, output, WIDTH, registered.
REQ-013 SHALL have ports Overflow, CarryOut, Negative and Zero, output, 1 each, registered, aligned with Result.

Function
REQ-014 SHALL accept an operation when in_valid and in_ready are both high; operands and opcode are captured in that cycle only.
REQ-015 SHALL drive in_ready = (state==IDLE) && (!out_valid || out_ready), so a result can drain and a new operation be accepted in the same cycle.
REQ-016 SHALL implement opcodes as follows (a sum of width WIDTH+1 gives CarryOut = bit WIDTH):
- 0000 A
- 0001 A+1
- 0010 A+B
- 0011 A+B+1
- 0100 A+~B
- 0101 A+~B+1
- 0110 A+all-ones (decrement)
- 0111 A
- 1000 A&B
- 1001 A|B
- 1010 A^B
- 1011 ~A
- 1100 B
- 1101 A<<B[SHW-1:0]
- 1110 A>>B[SHW-1:0] (logical)
- 1111 A*B, unsigned, low WIDTH bits.
REQ-017 SHALL set Overflow for 0001-0110 when both adder inputs share a sign bit and the result sign differs; for 1111 when the high WIDTH product bits are nonzero; otherwise 0.
REQ-018 SHALL set CarryOut for 0001-0110 to bit WIDTH of the sum; for shifts to the last bit shifted out (0 when the amount is 0); otherwise 0.
REQ-019 SHALL set Negative = Result[WIDTH-1] and Zero = (Result == 0) for every opcode.
REQ-020 SHALL complete opcodes 0000-1110 in one cycle: accepted in cycle t, out_valid visible in cycle t+1; sustained throughput is 1 operation per cycle under out_ready=1.
REQ-021 SHALL run 1111 as an iterative shift-add multiply: state IDLE->BUSY on accept; WIDTH BUSY cycles; then IDLE with out_valid visible in cycle t+WIDTH+1.
REQ-022 SHALL hold in_ready low throughout BUSY.
REQ-023 SHALL hold Result and the flags stable while out_valid && !out_ready.
REQ-024 SHALL clear out_valid after a handshake unless a new result loads in the same cycle.
REQ-025 SHALL, when a MUL finishes while a previous result is still unread, stay in BUSY (final iteration state held) until the output drains, then load.
REQ-026 SHALL give multiply-by-zero and all-ones operands no special-case latency.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, set state=IDLE, out_valid=0, Result=0 and all flags=0, and clear the multiply counter and partial product.
REQ-028 SHALL, on reset during BUSY, abort the multiply with no result ever emitted; in_ready is 1 in the first cycle after rst deasserts.
REQ-029 SHALL give rst priority over any simultaneous handshake.

Structure
REQ-030 SHALL take opcode constants (OP_TSA ... OP_MUL) and the state encoding (IDLE, BUSY) from shared package fu_pkg.
REQ-031 SHALL place the iterative multiplier in sub-module fu_mul_seq (start, operands, done, product of 2*WIDTH bits), instantiated once.
REQ-032 SHALL place the combinational op/flag logic in the top module.

Verification (WIDTH=16)
REQ-033 SHALL cover ADD: op 0010, A=0x7FFF, B=0x0001 -> Result=0x8000, V=1, N=1, C=0, Z=0, out_valid in cycle t+1.
REQ-034 SHALL cover SUB: op 0101, A=0x0005, B=0x0005 -> Result=0x0000, Z=1, C=1, V=0.
REQ-035 SHALL cover MUL: op 1111, A=0x0100, B=0x0100 -> Result=0x0000, V=1, Z=1, out_valid exactly in cycle t+17, in_ready=0 during cycles t+1..t+16.
REQ-036 SHALL cover SHL: op 1101, A=0x8001, B=0x0001 -> Result=0x0002, C=1; then op 1110, A=0x0001, B=0x0001 -> Result=0x0000, C=1, Z=1.
REQ-037 SHALL cover backpressure: out_ready=0 for 3 cycles after an ADD -> Result held, in_ready=0; out_ready=1 with a new in_valid -> drain and accept in the same cycle, next result in the following cycle.
REQ-038 SHALL cover reset mid-MUL: rst pulsed at cycle t+5 of a MUL -> out_valid=0 and Result=0 afterwards, in_ready=1 the cycle after reset, no late result.

Source files
------------

// File: rtl/fu_pkg.sv
// Shared opcode constants and controller state encoding for the sequential function unit.
package fu_pkg;

   localparam logic [3:0] OP_TSA  = 4'b0000;
   localparam logic [3:0] OP_INC  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_ADDC = 4'b0011;
   localparam logic [3:0] OP_SUBB = 4'b0100;
   localparam logic [3:0] OP_SUB  = 4'b0101;
   localparam logic [3:0] OP_DEC  = 4'b0110;
   localparam logic [3:0] OP_TSA7 = 4'b0111;
   localparam logic [3:0] OP_AND  = 4'b1000;
   localparam logic [3:0] OP_OR   = 4'b1001;
   localparam logic [3:0] OP_XOR  = 4'b1010;
   localparam logic [3:0] OP_NOTA = 4'b1011;
   localparam logic [3:0] OP_TSB  = 4'b1100;
   localparam logic [3:0] OP_SHL  = 4'b1101;
   localparam logic [3:0] OP_SHR  = 4'b1110;
   localparam logic [3:0] OP_MUL  = 4'b1111;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/fu_mul_seq.sv
// Iterative shift-add unsigned multiplier: one partial-product step per cycle, WIDTH steps.
// The last step is exposed combinationally so the product can be captured on the final edge.
module fu_mul_seq #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_start,
   input  logic [WIDTH-1:0]     i_a,
   input  logic [WIDTH-1:0]     i_b,
   input  logic                 i_hold,
   output logic                 o_done,
   output logic [2*WIDTH-1:0]   o_product
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic                 r_busy;
   logic [CW-1:0]        r_cnt;
   logic [2*WIDTH-1:0]   r_acc;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [2*WIDTH-1:0]   w_next_acc;

   assign w_next_acc = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign o_done     = r_busy && (r_cnt == LAST);
   assign o_product  = w_next_acc;

   // On the final step with i_hold set, all state freezes until the consumer frees the output
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy   <= 1'b0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
      end else if (i_start) begin
         r_busy   <= 1'b1;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= {{WIDTH{1'b0}}, i_a};
         r_mplier <= i_b;
      end else if (r_busy && !(o_done && i_hold)) begin
         r_acc    <= w_next_acc;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + CW'(1);
         if (o_done) begin
            r_busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/seq_function_unit.sv
// Function unit with valid/ready handshakes: single-cycle ALU/shift ops plus an iterative multiply.
// Result and flags are registered; the output holds under backpressure.
module seq_function_unit
   import fu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   input  logic [3:0]         FunctionSelect,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   Result,
   output logic               Overflow,
   output logic               CarryOut,
   output logic               Negative,
   output logic               Zero
);

   localparam int SHW = $clog2(WIDTH);

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_out_valid;
   logic [WIDTH-1:0]     r_result;
   logic                 r_ovf;
   logic                 r_carry;
   logic                 r_neg;
   logic                 r_zero;

   logic                 w_in_ready;
   logic                 w_load;
   logic                 w_load_mul;
   logic                 w_mul_start;
   logic                 w_mul_hold;
   logic                 w_mul_done;
   logic [2*WIDTH-1:0]   w_product;

   logic [SHW-1:0]       w_shamt;
   logic [WIDTH-1:0]     w_add_b;
   logic                 w_cin;
   logic [WIDTH:0]       w_sum;
   logic [WIDTH:0]       w_shl;
   logic [WIDTH:0]       w_shr;
   logic [WIDTH-1:0]     w_op_res;
   logic                 w_op_ovf;
   logic                 w_op_carry;
   logic [WIDTH-1:0]     w_ld_res;
   logic                 w_ld_ovf;
   logic                 w_ld_carry;

   // Shifts run one bit wider so the last bit shifted out lands in the extra bit (0 for amount 0)
   assign w_shamt = B[SHW-1:0];
   assign w_shl   = {1'b0, A} << w_shamt;
   assign w_shr   = {A, 1'b0} >> w_shamt;
   assign w_sum   = {1'b0, A} + {1'b0, w_add_b} + {{WIDTH{1'b0}}, w_cin};

   always_comb begin
      w_add_b = '0;
      w_cin   = 1'b0;
      case (FunctionSelect)
         OP_INC:  w_cin = 1'b1;
         OP_ADD:  w_add_b = B;
         OP_ADDC: begin
            w_add_b = B;
            w_cin   = 1'b1;
         end
         OP_SUBB: w_add_b = ~B;
         OP_SUB: begin
            w_add_b = ~B;
            w_cin   = 1'b1;
         end
         OP_DEC:  w_add_b = '1;
         default: ;
      endcase
   end

   always_comb begin
      w_op_res   = A;
      w_op_ovf   = 1'b0;
      w_op_carry = 1'b0;
      case (FunctionSelect)
         OP_INC, OP_ADD, OP_ADDC, OP_SUBB, OP_SUB, OP_DEC: begin
            w_op_res   = w_sum[WIDTH-1:0];
            w_op_carry = w_sum[WIDTH];
            w_op_ovf   = (A[WIDTH-1] == w_add_b[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
         end
         OP_AND:  w_op_res = A & B;
         OP_OR:   w_op_res = A | B;
         OP_XOR:  w_op_res = A ^ B;
         OP_NOTA: w_op_res = ~A;
         OP_TSB:  w_op_res = B;
         OP_SHL: begin
            w_op_res   = w_shl[WIDTH-1:0];
            w_op_carry = w_shl[WIDTH];
         end
         OP_SHR: begin
            w_op_res   = w_shr[WIDTH:1];
            w_op_carry = w_shr[0];
         end
         OP_TSA, OP_TSA7, OP_MUL: w_op_res = A;
         default: w_op_res = A;
      endcase
   end

   assign w_ld_res   = w_load_mul ? w_product[WIDTH-1:0] : w_op_res;
   assign w_ld_ovf   = w_load_mul ? (|w_product[2*WIDTH-1:WIDTH]) : w_op_ovf;
   assign w_ld_carry = w_load_mul ? 1'b0 : w_op_carry;

   fu_mul_seq #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk       (clk),
      .rst       (rst),
      .i_start   (w_mul_start),
      .i_a       (A),
      .i_b       (B),
      .i_hold    (w_mul_hold),
      .o_done    (w_mul_done),
      .o_product (w_product)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_load      = 1'b0;
      w_load_mul  = 1'b0;
      w_mul_start = 1'b0;
      w_mul_hold  = 1'b0;
      case (r_state)
         IDLE: begin
            w_in_ready = !r_out_valid || out_ready;
            if (in_valid && w_in_ready) begin
               if (FunctionSelect == OP_MUL) begin
                  w_mul_start = 1'b1;
                  w_state_nxt = BUSY;
               end else begin
                  w_load = 1'b1;
               end
            end
         end
         BUSY: begin
            if (w_mul_done) begin
               if (!r_out_valid || out_ready) begin
                  w_load      = 1'b1;
                  w_load_mul  = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_mul_hold = 1'b1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Output register: a new load wins over a drain in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_ovf       <= 1'b0;
         r_carry     <= 1'b0;
         r_neg       <= 1'b0;
         r_zero      <= 1'b0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_result    <= w_ld_res;
         r_ovf       <= w_ld_ovf;
         r_carry     <= w_ld_carry;
         r_neg       <= w_ld_res[WIDTH-1];
         r_zero      <= (w_ld_res == '0);
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign Result    = r_result;
   assign Overflow  = r_ovf;
   assign CarryOut  = r_carry;
   assign Negative  = r_neg;
   assign Zero      = r_zero;

endmodule

// File: tb/tb_seq_function_unit.sv
// Bench for seq_function_unit (WIDTH=16): opcode table through a scoreboard,
// plus hand sequences for multiply latency, backpressure and reset behaviour.
module tb_seq_function_unit;
   import fu_pkg::*;

   localparam int W  = 16;
   localparam int NV = 24;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  A = '0;
   logic [W-1:0]  B = '0;
   logic [3:0]    FunctionSelect = 4'h0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  Result;
   logic          Overflow;
   logic          CarryOut;
   logic          Negative;
   logic          Zero;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         v;
      logic         c;
      logic         n;
      logic         z;
   } vec_t;

   typedef struct {
      logic [W-1:0] res;
      logic         v;
      logic         c;
      logic         n;
      logic         z;
      int           id;
   } exp_t;

   exp_t q[$];
   exp_t exp_cur;
   vec_t tbl[NV];
   int   compared = 0;
   int   mismatched = 0;

   seq_function_unit #(.WIDTH(W)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .A              (A),
      .B              (B),
      .FunctionSelect (FunctionSelect),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .Result         (Result),
      .Overflow       (Overflow),
      .CarryOut       (CarryOut),
      .Negative       (Negative),
      .Zero           (Zero)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic exp_t mk(input logic [W-1:0] r, input logic v, input logic c,
                               input logic n, input logic z, input int id);
      exp_t e;
      e.res = r; e.v = v; e.c = c; e.n = n; e.z = z; e.id = id;
      return e;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic chkb(input string name, input logic act, input logic req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %b expected %b", name, act, req);
      end
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Called just after a rising edge; returns just after the accepting edge with in_valid low
   task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input exp_t e);
      int n = 0;
      in_valid       = 1'b1;
      FunctionSelect = op;
      A              = a;
      B              = b;
      exp_cur        = e;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         compared++;
         mismatched++;
         $display("FAIL accept_timeout: in_ready 0 expected 1");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Scoreboard: push on accepted handshake, pop on output handshake; reset discards in-flight ops
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst) begin
         q.delete();
      end else begin
         if (out_valid && out_ready) begin
            compared++;
            if (q.size() == 0) begin
               mismatched++;
               $display("FAIL unexpected_result: got %h expected none", Result);
            end else begin
               e = q.pop_front();
               if ({Result, Overflow, CarryOut, Negative, Zero} !== {e.res, e.v, e.c, e.n, e.z}) begin
                  mismatched++;
                  $display("FAIL result[%0d]: got %h V%b C%b N%b Z%b expected %h V%b C%b N%b Z%b",
                           e.id, Result, Overflow, CarryOut, Negative, Zero,
                           e.res, e.v, e.c, e.n, e.z);
               end
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(exp_cur);
         end
      end
   end

   initial begin
      int k;
      int bad_rdy;
      int early;
      int late;
      logic [W-1:0] ma[3];
      logic [W-1:0] mb[3];
      exp_t         me[3];

      //                op       A         B         Result    V     C     N     Z
      tbl[0]  = '{OP_TSA,  16'h1234, 16'hFFFF, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{OP_INC,  16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[2]  = '{OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{OP_ADDC, 16'h8000, 16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{OP_SUBB, 16'h0005, 16'h0003, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{OP_SUB,  16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[6]  = '{OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{OP_DEC,  16'h0000, 16'h1111, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[8]  = '{OP_DEC,  16'h8000, 16'h0000, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{OP_TSA7, 16'h8000, 16'h0000, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[10] = '{OP_AND,  16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{OP_OR,   16'hF000, 16'h000F, 16'hF00F, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[12] = '{OP_XOR,  16'hAAAA, 16'hAAAA, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[13] = '{OP_NOTA, 16'h00FF, 16'h0000, 16'hFF00, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[14] = '{OP_TSB,  16'h1111, 16'h8001, 16'h8001, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[15] = '{OP_SHL,  16'h8001, 16'h0001, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[16] = '{OP_SHR,  16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[17] = '{OP_SHL,  16'h1234, 16'h0010, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[18] = '{OP_SHR,  16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[19] = '{OP_SHL,  16'h0003, 16'h000F, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[20] = '{OP_MUL,  16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[21] = '{OP_MUL,  16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[22] = '{OP_MUL,  16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[23] = '{OP_MUL,  16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};

      // Reset held across an offered operation: reset must win, nothing is loaded
      repeat (3) sync();
      in_valid = 1'b1; FunctionSelect = OP_TSA; A = 16'h1234; B = 16'h0000;
      sync();
      in_valid = 1'b0;
      rst      = 1'b0;
      @(negedge clk);
      chkb("rst_out_valid", out_valid, 1'b0);
      chk ("rst_result", Result, 16'h0000);
      chk ("rst_flags", {12'h000, Overflow, CarryOut, Negative, Zero}, 16'h0000);
      chkb("rst_in_ready", in_ready, 1'b1);
      sync();

      for (int i = 0; i < NV; i++) begin
         send(tbl[i].op, tbl[i].a, tbl[i].b,
              mk(tbl[i].res, tbl[i].v, tbl[i].c, tbl[i].n, tbl[i].z, i));
      end
      k = 0;
      while (q.size() != 0 && k < 100) begin
         sync();
         k++;
      end
      chk("table_drained", 16'(q.size()), 16'h0000);
      repeat (2) sync();

      // Single-cycle latency
      send(OP_ADD, 16'h7FFF, 16'h0001, mk(16'h8000, 1'b1, 1'b0, 1'b1, 1'b0, 100));
      @(negedge clk);
      chkb("add_lat1", out_valid, 1'b1);
      repeat (2) sync();

      // Multiply: busy for exactly WIDTH cycles regardless of operand values
      ma[0] = 16'h0100; mb[0] = 16'h0100; me[0] = mk(16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 200);
      ma[1] = 16'hFFFF; mb[1] = 16'hFFFF; me[1] = mk(16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 201);
      ma[2] = 16'h0000; mb[2] = 16'h0000; me[2] = mk(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 202);
      for (int p = 0; p < 3; p++) begin
         send(OP_MUL, ma[p], mb[p], me[p]);
         bad_rdy = 0;
         early   = 0;
         for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (in_ready)  bad_rdy++;
            if (out_valid) early++;
         end
         chk ("mul_busy_in_ready", 16'(bad_rdy), 16'h0000);
         chk ("mul_early_valid", 16'(early), 16'h0000);
         @(negedge clk);
         chkb("mul_lat17", out_valid, 1'b1);
         repeat (2) sync();
      end

      // Backpressure: result held three cycles, then drain and accept together
      out_ready = 1'b0;
      send(OP_ADD, 16'h0001, 16'h0002, mk(16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 300));
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chkb("bp_valid", out_valid, 1'b1);
         chk ("bp_result", Result, 16'h0003);
         chkb("bp_in_ready", in_ready, 1'b0);
      end
      sync();
      out_ready      = 1'b1;
      in_valid       = 1'b1;
      FunctionSelect = OP_XOR;
      A              = 16'h00FF;
      B              = 16'h0F0F;
      exp_cur        = mk(16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0, 301);
      @(negedge clk);
      chkb("bp_drain_accept", in_ready, 1'b1);
      sync();
      in_valid = 1'b0;
      @(negedge clk);
      chkb("bp_next_valid", out_valid, 1'b1);
      chk ("bp_next_result", Result, 16'h0FF0);
      repeat (2) sync();

      // Reset in cycle t+5 of a multiply: aborted, never emitted
      send(OP_MUL, 16'h0003, 16'h0005, mk(16'h000F, 1'b0, 1'b0, 1'b0, 1'b0, 400));
      repeat (4) sync();
      rst = 1'b1;
      sync();
      rst = 1'b0;
      @(negedge clk);
      chkb("abort_valid", out_valid, 1'b0);
      chk ("abort_result", Result, 16'h0000);
      chkb("abort_in_ready", in_ready, 1'b1);
      late = 0;
      repeat (30) begin
         @(negedge clk);
         if (out_valid) late++;
      end
      chk("abort_no_late", 16'(late), 16'h0000);
      chk("final_queue_empty", 16'(q.size()), 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
